// File: rtl/pipe_run_controller_pkg.sv
// Shared definitions for the debug pipeline run controller: command codes,
// FSM state encoding, stop-cause codes and the stop-cause priority encoder.
package pipe_run_controller_pkg;

  typedef enum logic [2:0] {
    CMD_NOP        = 3'd0,
    CMD_RESET_PIPE = 3'd1,
    CMD_RUN        = 3'd2,
    CMD_STEP       = 3'd3,
    CMD_HALT       = 3'd4,
    CMD_SET_BREAK  = 3'd5,
    CMD_CLR_BREAK  = 3'd6,
    CMD_RSVD       = 3'd7
  } cmd_code_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESET = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_SNAP   = 3'd4
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_END      = 3'd1,
    CAUSE_BREAK    = 3'd2,
    CAUSE_WATCHDOG = 3'd3,
    CAUSE_HALT     = 3'd4,
    CAUSE_STEP     = 3'd5
  } halt_cause_t;

  // Highest-priority reason for a RUN stop; HALT is the fallback because a
  // stop with none of the other three conditions can only be a HALT command.
  function automatic halt_cause_t stop_cause(input logic end_lvl,
                                             input logic bp_hit,
                                             input logic wd_hit);
    if (end_lvl)     return CAUSE_END;
    else if (bp_hit) return CAUSE_BREAK;
    else if (wd_hit) return CAUSE_WATCHDOG;
    else             return CAUSE_HALT;
  endfunction

endpackage

// File: rtl/pipe_run_controller_if.sv
// Command channel from debugger_rx into the run controller.
interface pipe_run_controller_if #(
  parameter int PC_WIDTH = 10
);
  import pipe_run_controller_pkg::*;

  logic                cmd_valid;
  cmd_code_t           cmd_code;
  logic [PC_WIDTH-1:0] cmd_arg;
  logic                cmd_ready;
  logic                cmd_err;

  // Command source (debugger_rx side).
  modport master (output cmd_valid, cmd_code, cmd_arg, input cmd_ready, cmd_err);
  // Command sink (controller side).
  modport slave  (input cmd_valid, cmd_code, cmd_arg, output cmd_ready, cmd_err);
endinterface

// File: rtl/pipe_bp_watch.sv
// Breakpoint register and per-RUN enable counter; flags a breakpoint match
// and the watchdog limit for the run controller.
module pipe_bp_watch #(
  parameter int PC_WIDTH = 10,
  parameter int MAX_RUN  = 1000
) (
  input  logic                clock,
  input  logic                reset,      // asynchronous, active-low
  input  logic                set_bp,
  input  logic                clr_bp,
  input  logic [PC_WIDTH-1:0] bp_arg,
  input  logic                run_start,
  input  logic                run_adv,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                bp_hit,
  output logic                wd_hit
);
  localparam int RUN_W = $clog2(MAX_RUN + 1);

  logic [PC_WIDTH-1:0] bp_pc;
  logic                bp_en;
  logic [RUN_W-1:0]    run_cnt;
  logic                first_run_cycle;

  // Breakpoint register, first-cycle marker and enables counted in this RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bp_pc           <= '0;
      bp_en           <= 1'b0;
      run_cnt         <= '0;
      first_run_cycle <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (set_bp) begin
        bp_pc <= bp_arg;
        bp_en <= 1'b1;
      end else if (clr_bp) begin
        bp_en <= 1'b0;
      end
      first_run_cycle <= run_start;
      if (run_start)    run_cnt <= '0;
      else if (run_adv) run_cnt <= run_cnt + 1'b1;
    end
  end

  // The first RUN cycle ignores the breakpoint so a stopped pipeline can resume.
  assign bp_hit = bp_en & (pc == bp_pc) & ~first_run_cycle;
  assign wd_hit = (run_cnt == RUN_W'(MAX_RUN));

endmodule

// File: rtl/pipe_run_controller.sv
// Debug pipeline run controller: sequences pipeline reset and clock enable,
// runs continuously or single-steps, stops on end/breakpoint/watchdog/HALT
// and hands off to debugger_tx for a snapshot after every stop.
module pipe_run_controller
  import pipe_run_controller_pkg::*;
#(
  parameter int PC_WIDTH     = 10,
  parameter int CNT_WIDTH    = 16,
  parameter int MAX_RUN      = 1000,
  parameter int RESET_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,        // asynchronous, active-low
  pipe_run_controller_if.slave cmd,
  input  logic [PC_WIDTH-1:0]  pc_ifid,
  input  logic                 program_end,
  input  logic                 snap_done,
  output logic                 pipe_clk_en,
  output logic                 pipe_reset,
  output logic                 clear_end,
  output logic                 snap_req,
  output logic [2:0]           state,
  output logic [2:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_count
);
  localparam int PRESET_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_t          cur;
  logic                alive;       // low only until the first edge after reset
  logic [PRESET_W-1:0] preset_cnt;
  logic                accept;
  logic                in_idle;
  logic                halt_cmd;
  logic                stop;
  logic                bp_hit;
  logic                wd_hit;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign in_idle       = (cur == ST_IDLE);
  assign cmd.cmd_ready = alive & (in_idle | (cur == ST_RUN));
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign halt_cmd      = (cur == ST_RUN) & accept & (cmd.cmd_code == CMD_HALT);
  assign stop          = program_end | bp_hit | wd_hit | halt_cmd;
  // The enable is decoded combinationally so a stop suppresses it in the same cycle.
  assign pipe_clk_en   = (cur == ST_PRESET) | (cur == ST_STEP) | ((cur == ST_RUN) & ~stop);
  assign state         = cur;

  pipe_bp_watch #(
    .PC_WIDTH (PC_WIDTH),
    .MAX_RUN  (MAX_RUN)
  ) u_bp_watch (
    .clock     (clock),
    .reset     (reset),
    .set_bp    (in_idle & accept & (cmd.cmd_code == CMD_SET_BREAK)),
    .clr_bp    (in_idle & accept & (cmd.cmd_code == CMD_CLR_BREAK)),
    .bp_arg    (cmd.cmd_arg),
    .run_start (in_idle & accept & (cmd.cmd_code == CMD_RUN)),
    .run_adv   ((cur == ST_RUN) & ~stop),
    .pc        (pc_ifid),
    .bp_hit    (bp_hit),
    .wd_hit    (wd_hit)
  );

  // Controller FSM with its registered pulse, level and counter outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur         <= ST_IDLE;
      alive       <= 1'b0;
      preset_cnt  <= '0;
      pipe_reset  <= 1'b0;
      clear_end   <= 1'b0;
      snap_req    <= 1'b0;
      cmd.cmd_err <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      cycle_count <= '0;
    end else begin
      // NOTE: pulse outputs default low here; a later assignment in the same branch wins for one cycle.
      alive       <= 1'b1;
      clear_end   <= 1'b0;
      cmd.cmd_err <= 1'b0;
      unique case (cur)
        ST_IDLE: begin
          if (accept) begin
            case (cmd.cmd_code)
              CMD_RESET_PIPE: begin
                cur         <= ST_PRESET;
                preset_cnt  <= '0;
                pipe_reset  <= 1'b1;
                clear_end   <= 1'b1;
                cycle_count <= '0;
                halt_cause  <= CAUSE_NONE;
              end
              CMD_RUN: cur <= ST_RUN;
              CMD_STEP: begin
                if (program_end) begin
                  cur        <= ST_SNAP;
                  snap_req   <= 1'b1;
                  halt_cause <= CAUSE_END;
                end else begin
                  cur <= ST_STEP;
                end
              end
              CMD_RSVD: cmd.cmd_err <= 1'b1;
              default: ;  // NOP, HALT and breakpoint edits change no FSM state
            endcase
          end
        end
        ST_PRESET: begin
          if (preset_cnt == PRESET_W'(RESET_CYCLES - 1)) begin
            cur        <= ST_IDLE;
            pipe_reset <= 1'b0;
          end else begin
            preset_cnt <= preset_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (accept && (cmd.cmd_code != CMD_HALT)) cmd.cmd_err <= 1'b1;
          if (stop) begin
            cur        <= ST_SNAP;
            snap_req   <= 1'b1;
            halt_cause <= stop_cause(program_end, bp_hit, wd_hit);
          end else begin
            cycle_count <= sat_inc(cycle_count);
          end
        end
        ST_STEP: begin
          cycle_count <= sat_inc(cycle_count);
          halt_cause  <= CAUSE_STEP;
          cur         <= ST_SNAP;
          snap_req    <= 1'b1;
        end
        ST_SNAP: begin
          if (snap_done) begin
            cur      <= ST_IDLE;
            snap_req <= 1'b0;
          end
        end
        default: cur <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_run_controller.sv
// Bench for pipe_run_controller: directed vector table, hand-written corner
// sequences (step counting, reset during SNAP and RUN) and a randomized phase
// scored against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pipe_run_controller;
  import pipe_run_controller_pkg::*;

  localparam int PC_WIDTH     = 10;
  localparam int CNT_WIDTH    = 16;
  localparam int MAX_RUN      = 5;
  localparam int RESET_CYCLES = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [PC_WIDTH-1:0]  pc_ifid;
  logic                 program_end;
  logic                 snap_done;
  logic                 pipe_clk_en, pipe_reset, clear_end, snap_req;
  logic [2:0]           state, halt_cause;
  logic [CNT_WIDTH-1:0] cycle_count;

  pipe_run_controller_if #(.PC_WIDTH(PC_WIDTH)) cmd_bus ();

  pipe_run_controller #(
    .PC_WIDTH     (PC_WIDTH),
    .CNT_WIDTH    (CNT_WIDTH),
    .MAX_RUN      (MAX_RUN),
    .RESET_CYCLES (RESET_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd         (cmd_bus),
    .pc_ifid     (pc_ifid),
    .program_end (program_end),
    .snap_done   (snap_done),
    .pipe_clk_en (pipe_clk_en),
    .pipe_reset  (pipe_reset),
    .clear_end   (clear_end),
    .snap_req    (snap_req),
    .state       (state),
    .halt_cause  (halt_cause),
    .cycle_count (cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  st;
    logic        en, rdy, err, prst, ce, sr;
    logic [2:0]  hc;
    logic [15:0] cc;
  } outs_t;

  typedef struct {
    bit    v;
    int    code, arg;
    bit    pe, sd;
    int    pc;
    outs_t exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic outs_t sample();
    outs_t s;
    s.st = state;           s.en = pipe_clk_en;  s.rdy = cmd_bus.cmd_ready;
    s.err = cmd_bus.cmd_err; s.prst = pipe_reset; s.ce = clear_end;
    s.sr = snap_req;        s.hc = halt_cause;   s.cc = cycle_count;
    return s;
  endfunction

  task automatic check_outs(input string name, input outs_t act, input outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d en=%0b rdy=%0b err=%0b prst=%0b ce=%0b sr=%0b hc=%0d cc=%0d, expected st=%0d en=%0b rdy=%0b err=%0b prst=%0b ce=%0b sr=%0b hc=%0d cc=%0d",
               name, act.st, act.en, act.rdy, act.err, act.prst, act.ce, act.sr, act.hc, act.cc,
               exp.st, exp.en, exp.rdy, exp.err, exp.prst, exp.ce, exp.sr, exp.hc, exp.cc);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int code, input int arg,
                       input bit pe, input bit sd, input int pc);
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_code  = cmd_code_t'(code[2:0]);
    cmd_bus.cmd_arg   = arg[PC_WIDTH-1:0];
    program_end       = pe;
    snap_done         = sd;
    pc_ifid           = pc[PC_WIDTH-1:0];
  endtask

  // One cycle: new inputs at the falling edge, outputs settled 1 ns later.
  task automatic cycle(input bit v, input int code, input int arg,
                       input bit pe, input bit sd, input int pc);
    @(negedge clock);
    drive(v, code, arg, pe, sd, pc);
    #1;
  endtask

  function automatic void add(input bit v, input int code, input int arg, input bit pe,
                              input bit sd, input int pc, input int st, input bit en,
                              input bit rdy, input bit err, input bit prst, input bit ce,
                              input bit sr, input int hc, input int cc);
    vec_t r;
    r.v = v; r.code = code; r.arg = arg; r.pe = pe; r.sd = sd; r.pc = pc;
    r.exp.st = 3'(st); r.exp.en = en; r.exp.rdy = rdy; r.exp.err = err;
    r.exp.prst = prst; r.exp.ce = ce; r.exp.sr = sr; r.exp.hc = 3'(hc); r.exp.cc = 16'(cc);
    tbl.push_back(r);
  endfunction

  task automatic wait_snap(input string name);
    for (int i = 0; i < 20; i++) begin
      if (snap_req === 1'b1) break;
      cycle(0, 0, 0, 0, 0, 0);
    end
    check(name, 32'(snap_req), 32'd1);
  endtask

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, 1 pipeline reset, 2 running, 3 single step, 4 awaiting snapshot
  int m_mode, m_preset_left, m_runs, m_bp_pc, m_cc, m_hc, m_pc;
  bit m_first, m_bp_en, m_sr, m_ce, m_err, m_alive;

  task automatic model_reset();
    m_mode = 0; m_preset_left = 0; m_runs = 0; m_bp_pc = 0; m_cc = 0; m_hc = 0;
    m_pc = 0; m_first = 0; m_bp_en = 0; m_sr = 0; m_ce = 0; m_err = 0; m_alive = 1;
  endtask

  task automatic model_step(input bit v, input int code, input int arg, input bit pe,
                            input bit sd, input int pc, output outs_t exp);
    bit rdy, acc, bp, wd, halt, stop, en;
    rdy  = m_alive && (m_mode == 0 || m_mode == 2);
    acc  = v && rdy;
    bp   = m_bp_en && (pc == m_bp_pc) && !m_first;
    wd   = (m_runs == MAX_RUN);
    halt = (m_mode == 2) && acc && (code == 4);
    stop = pe || bp || wd || halt;
    en   = (m_mode == 1) || (m_mode == 3) || (m_mode == 2 && !stop);
    exp.st = 3'(m_mode); exp.en = en; exp.rdy = rdy; exp.err = m_err;
    exp.prst = (m_mode == 1); exp.ce = m_ce; exp.sr = m_sr;
    exp.hc = 3'(m_hc); exp.cc = 16'(m_cc);
    m_err = 0; m_ce = 0; m_first = 0;
    case (m_mode)
      0: if (acc) begin
        if (code == 1) begin
          m_mode = 1; m_preset_left = RESET_CYCLES; m_cc = 0; m_hc = 0; m_ce = 1;
        end else if (code == 2) begin
          m_mode = 2; m_runs = 0; m_first = 1;
        end else if (code == 3) begin
          if (pe) begin m_mode = 4; m_hc = 1; m_sr = 1; end
          else m_mode = 3;
        end else if (code == 5) begin
          m_bp_en = 1; m_bp_pc = arg;
        end else if (code == 6) begin
          m_bp_en = 0;
        end else if (code == 7) begin
          m_err = 1;
        end
      end
      1: begin
        m_preset_left--;
        if (m_preset_left == 0) m_mode = 0;
      end
      2: begin
        if (acc && code != 4) m_err = 1;
        if (stop) begin
          m_mode = 4; m_sr = 1;
          m_hc = pe ? 1 : bp ? 2 : wd ? 3 : 4;
        end else begin
          m_runs++;
          if (m_cc < 65535) m_cc++;
        end
      end
      3: begin
        if (m_cc < 65535) m_cc++;
        m_hc = 5; m_mode = 4; m_sr = 1;
      end
      default: if (sd) begin m_mode = 0; m_sr = 0; end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    outs_t zero;
    outs_t exp;
    bit    v, pe, sd;
    int    code, arg;
    zero = '0;

    drive(0, 0, 0, 0, 0, 0);
    #12;
    check_outs("reset_hold", sample(), zero);
    @(negedge clock);
    reset = 1'b1;

    //   v code arg pe sd pc | st en rdy err prst ce sr hc cc
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0);  // RESET_PIPE
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 7, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0);  // reserved
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 5, 8, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0);  // SET_BREAK 0x008
    add(1, 2, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 0, 0, 0);  // RUN
    add(0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4,   2, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 8,   2, 0, 1, 0, 0, 0, 0, 0, 2);  // breakpoint
    add(0, 0, 0, 0, 0, 8,   4, 0, 0, 0, 0, 0, 1, 2, 2);
    add(0, 0, 0, 0, 1, 8,   4, 0, 0, 0, 0, 0, 1, 2, 2);
    add(0, 0, 0, 0, 0, 8,   0, 0, 1, 0, 0, 0, 0, 2, 2);
    add(1, 2, 0, 0, 0, 8,   0, 0, 1, 0, 0, 0, 0, 2, 2);  // resume RUN
    add(0, 0, 0, 0, 0, 8,   2, 1, 1, 0, 0, 0, 0, 2, 2);  // breakpoint skipped
    add(1, 4, 0, 1, 0, 12,  2, 0, 1, 0, 0, 0, 0, 2, 3);  // END and HALT together
    add(0, 0, 0, 0, 0, 12,  4, 0, 0, 0, 0, 0, 1, 1, 3);
    add(1, 3, 0, 0, 1, 12,  4, 0, 0, 0, 0, 0, 1, 1, 3);  // command ignored in SNAP
    add(0, 0, 0, 0, 0, 12,  0, 0, 1, 0, 0, 0, 0, 1, 3);
    add(1, 3, 0, 0, 0, 12,  0, 0, 1, 0, 0, 0, 0, 1, 3);  // STEP
    add(0, 0, 0, 0, 0, 12,  3, 1, 0, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 0, 12,  4, 0, 0, 0, 0, 0, 1, 5, 4);
    add(0, 0, 0, 0, 1, 12,  4, 0, 0, 0, 0, 0, 1, 5, 4);
    add(0, 0, 0, 0, 0, 12,  0, 0, 1, 0, 0, 0, 0, 5, 4);
    add(1, 3, 0, 1, 0, 12,  0, 0, 1, 0, 0, 0, 0, 5, 4);  // STEP at program end
    add(0, 0, 0, 0, 0, 12,  4, 0, 0, 0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 1, 12,  4, 0, 0, 0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 0, 12,  0, 0, 1, 0, 0, 0, 0, 1, 4);
    add(1, 2, 0, 1, 0, 8,   0, 0, 1, 0, 0, 0, 0, 1, 4);  // RUN at program end
    add(0, 0, 0, 1, 0, 8,   2, 0, 1, 0, 0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 8,   4, 0, 0, 0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 1, 8,   4, 0, 0, 0, 0, 0, 1, 1, 4);
    add(0, 0, 0, 0, 0, 8,   0, 0, 1, 0, 0, 0, 0, 1, 4);
    add(1, 6, 0, 0, 0, 8,   0, 0, 1, 0, 0, 0, 0, 1, 4);  // CLR_BREAK
    add(1, 2, 0, 0, 0, 8,   0, 0, 1, 0, 0, 0, 0, 1, 4);  // RUN to watchdog
    add(1, 3, 0, 0, 0, 8,   2, 1, 1, 0, 0, 0, 0, 1, 4);  // STEP dropped
    add(0, 0, 0, 0, 0, 8,   2, 1, 1, 1, 0, 0, 0, 1, 5);
    add(0, 0, 0, 0, 0, 8,   2, 1, 1, 0, 0, 0, 0, 1, 6);
    add(0, 0, 0, 0, 0, 8,   2, 1, 1, 0, 0, 0, 0, 1, 7);
    add(0, 0, 0, 0, 0, 8,   2, 1, 1, 0, 0, 0, 0, 1, 8);
    add(0, 0, 0, 0, 0, 8,   2, 0, 1, 0, 0, 0, 0, 1, 9);  // watchdog
    add(0, 0, 0, 0, 0, 8,   4, 0, 0, 0, 0, 0, 1, 3, 9);
    add(0, 0, 0, 0, 0, 8,   4, 0, 0, 0, 0, 0, 1, 3, 9);  // held
    add(0, 0, 0, 0, 1, 8,   4, 0, 0, 0, 0, 0, 1, 3, 9);
    add(0, 0, 0, 0, 0, 8,   0, 0, 1, 0, 0, 0, 0, 3, 9);
    add(1, 2, 0, 0, 0, 8,   0, 0, 1, 0, 0, 0, 0, 3, 9);  // RUN then HALT
    add(0, 0, 0, 0, 0, 8,   2, 1, 1, 0, 0, 0, 0, 3, 9);
    add(1, 4, 0, 0, 0, 8,   2, 0, 1, 0, 0, 0, 0, 3, 10);
    add(0, 0, 0, 0, 0, 8,   4, 0, 0, 0, 0, 0, 1, 4, 10);
    add(0, 0, 0, 0, 1, 8,   4, 0, 0, 0, 0, 0, 1, 4, 10);
    add(0, 0, 0, 0, 1, 8,   0, 0, 1, 0, 0, 0, 0, 4, 10); // snap_done ignored in IDLE
    add(0, 0, 0, 0, 0, 8,   0, 0, 1, 0, 0, 0, 0, 4, 10);

    foreach (tbl[i]) begin
      cycle(tbl[i].v, tbl[i].code, tbl[i].arg, tbl[i].pe, tbl[i].sd, tbl[i].pc);
      check_outs($sformatf("vec%0d", i), sample(), tbl[i].exp);
    end

    // STEP x3 after a pipeline reset.
    cycle(1, CMD_RESET_PIPE, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    check("preset_cc", 32'(cycle_count), 32'd0);
    for (int s = 0; s < 3; s++) begin
      cycle(1, CMD_STEP, 0, 0, 0, 0);
      wait_snap($sformatf("step%0d_snap", s));
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0);
    end
    check("step3_cc", 32'(cycle_count), 32'd3);
    check("step3_cause", 32'(halt_cause), 32'd5);

    // Reset asserted while waiting for the snapshot.
    cycle(1, CMD_STEP, 0, 0, 0, 0);
    wait_snap("step4_snap");
    reset = 1'b0;
    #1;
    check_outs("reset_in_snap", sample(), zero);
    @(posedge clock);
    #1;
    check_outs("reset_in_snap_hold", sample(), zero);
    @(negedge clock);
    reset = 1'b1;

    // Reset asserted mid-RUN.
    cycle(1, CMD_RUN, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("run_en", 32'(pipe_clk_en), 32'd1);
    reset = 1'b0;
    #1;
    check_outs("reset_in_run", sample(), zero);

    // Randomized phase against the reference model.
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      v    = ($urandom_range(0, 9) < 4);
      code = ($urandom_range(0, 3) == 0) ? CMD_RUN : $urandom_range(0, 7);
      arg  = 4 * $urandom_range(0, 15);
      pe   = ($urandom_range(0, 99) < 3);
      sd   = ($urandom_range(0, 2) == 0);
      cycle(v, code, arg, pe, sd, m_pc);
      model_step(v, code, arg, pe, sd, m_pc, exp);
      check_outs($sformatf("rand%0d", n), sample(), exp);
      if (exp.prst) m_pc = 0;
      else if (exp.en) m_pc = (m_pc + 4) % 64;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
